// File: rtl/router_pkg.sv
// Shared constants and port naming for the router switch allocator.
package router_pkg;

    localparam int NPORTS = 5;
    localparam int DATA_W = 32;
    localparam int PORT_W = 3;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

endpackage

// File: rtl/router_switch_allocator_if.sv
// Request/grant/output bundle between the input FIFOs, the allocator and the output links.
interface router_switch_allocator_if
    import router_pkg::*;
#(
    parameter int NPORTS = router_pkg::NPORTS,
    parameter int DATA_W = router_pkg::DATA_W
);

    logic [NPORTS-1:0]             req_valid;
    logic [NPORTS-1:0][PORT_W-1:0] req_port;
    logic [NPORTS-1:0][DATA_W-1:0] data_in;
    logic [NPORTS-1:0]             hold_in;
    logic [NPORTS-1:0]             pop;
    logic [NPORTS-1:0]             valid_out;
    logic [NPORTS-1:0][DATA_W-1:0] data_out;
    logic                          err_bad_port;

    modport master (
        output req_valid,
        output req_port,
        output data_in,
        output hold_in,
        input  pop,
        input  valid_out,
        input  data_out,
        input  err_bad_port
    );

    modport slave (
        input  req_valid,
        input  req_port,
        input  data_in,
        input  hold_in,
        output pop,
        output valid_out,
        output data_out,
        output err_bad_port
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output: one-hot grant starting the search at the stored pointer.
module rr_arbiter
    import router_pkg::*;
#(
    parameter int NPORTS = router_pkg::NPORTS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              enable,
    output logic [NPORTS-1:0] grant
);

    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [PTR_W-1:0] ptrQ, ptrD;

    // First pass covers indices at or above the pointer, second pass wraps to the bottom.
    always_comb begin
        logic found;
        grant = '0;
        ptrD  = ptrQ;
        found = 1'b0;
        if (enable) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (!found && req[i] && (i >= int'(ptrQ))) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                    ptrD     = (i == NPORTS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (!found && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                    ptrD     = (i == NPORTS - 1) ? '0 : PTR_W'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptrQ <= '0;
        end else begin
            ptrQ <= ptrD;
        end
    end

endmodule

// File: rtl/router_switch_allocator.sv
// Switch allocator: per-output round-robin arbitration, FIFO pops, and registered output links.
module router_switch_allocator #(
    parameter int NPORTS = router_pkg::NPORTS,
    parameter int DATA_W = router_pkg::DATA_W
) (
    input logic                      clk,
    input logic                      reset,
    router_switch_allocator_if.slave bus
);

    import router_pkg::*;

    logic [NPORTS-1:0]             portReq   [NPORTS];
    logic [NPORTS-1:0]             portGrant [NPORTS];
    logic [NPORTS-1:0]             popVec;
    logic [NPORTS-1:0]             validD, validQ;
    logic [NPORTS-1:0][DATA_W-1:0] dataD, dataQ;
    logic                          errD, errQ;

    // Out-of-range destinations match no output, so they are never granted.
    always_comb begin
        for (int j = 0; j < NPORTS; j++) begin
            for (int i = 0; i < NPORTS; i++) begin
                portReq[j][i] = bus.req_valid[i] && (int'(bus.req_port[i]) == j);
            end
        end
    end

    for (genvar j = 0; j < NPORTS; j++) begin : gArb
        rr_arbiter #(
            .NPORTS (NPORTS)
        ) uArb (
            .clk    (clk),
            .reset  (reset),
            .req    (portReq[j]),
            .enable (reset && !bus.hold_in[j]),
            .grant  (portGrant[j])
        );
    end

    always_comb begin
        popVec = '0;
        validD = '0;
        dataD  = dataQ;
        errD   = errQ;
        for (int j = 0; j < NPORTS; j++) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (portGrant[j][i]) begin
                    popVec[i] = 1'b1;
                    validD[j] = 1'b1;
                    dataD[j]  = bus.data_in[i];
                end
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            if (bus.req_valid[i] && (int'(bus.req_port[i]) >= NPORTS)) begin
                errD = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ <= '0;
            dataQ  <= '0;
            errQ   <= 1'b0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
            errQ   <= errD;
        end
    end

    assign bus.pop          = popVec;
    assign bus.valid_out    = validQ;
    assign bus.data_out     = dataQ;
    assign bus.err_bad_port = errQ;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Directed bench for router_switch_allocator with hand-computed expectations.
module tb_router_switch_allocator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   order [5] = '{0, 2, 4, 0, 2};

    router_switch_allocator_if #(.NPORTS(5), .DATA_W(32)) bus ();

    router_switch_allocator #(
        .NPORTS (5),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkV(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkD(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkB(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.data_in   = '0;
        bus.hold_in   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkV("rst_valid", bus.valid_out, 5'b00000);
        checkB("rst_data_zero", bus.data_out == '0, 1'b1);
        checkB("rst_err", bus.err_bad_port, 1'b0);
        checkV("rst_pop", bus.pop, 5'b00000);
        @(negedge clk);
        reset = 1'b1;

        // Single transfer input 2 -> output 1
        @(posedge clk);
        #1;
        bus.req_valid   = 5'b00100;
        bus.req_port[2] = 3'd1;
        bus.data_in[2]  = 32'h845FFFFF;
        @(negedge clk);
        #1;
        checkV("single_pop", bus.pop, 5'b00100);
        @(posedge clk);
        #1;
        checkV("single_valid", bus.valid_out, 5'b00010);
        checkD("single_data", bus.data_out[1], 32'h845FFFFF);
        bus.req_valid = '0;
        @(negedge clk);
        #1;
        checkV("idle_pop", bus.pop, 5'b00000);
        @(posedge clk);
        #1;
        checkV("idle_valid", bus.valid_out, 5'b00000);
        checkD("idle_data_hold", bus.data_out[1], 32'h845FFFFF);

        // Inputs 0, 2, 4 contend for output 3
        bus.req_valid   = 5'b10101;
        bus.req_port[0] = 3'd3;
        bus.req_port[2] = 3'd3;
        bus.req_port[4] = 3'd3;
        bus.data_in[0]  = 32'h000000A0;
        bus.data_in[2]  = 32'h000000A2;
        bus.data_in[4]  = 32'h000000A4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checkV("rr_pop", bus.pop, 5'(1 << order[k]));
            @(posedge clk);
            #1;
            checkV("rr_valid", bus.valid_out, 5'b01000);
            checkD("rr_data", bus.data_out[3], 32'hA0 + order[k]);
        end

        // Full hold for 10 cycles, input 2 waiting on output 1
        bus.hold_in     = 5'b11111;
        bus.req_valid   = 5'b00100;
        bus.req_port[2] = 3'd1;
        bus.data_in[2]  = 32'h22222222;
        checkV("hold_keeps_registered", bus.valid_out, 5'b01000);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            checkV("hold_pop", bus.pop, 5'b00000);
            @(posedge clk);
            #1;
            checkV("hold_valid", bus.valid_out, 5'b00000);
        end
        bus.hold_in = 5'b11101;
        @(negedge clk);
        #1;
        checkV("unhold_pop", bus.pop, 5'b00100);
        @(posedge clk);
        #1;
        checkV("unhold_valid", bus.valid_out, 5'b00010);
        checkD("unhold_data", bus.data_out[1], 32'h22222222);

        // All five inputs to distinct outputs
        bus.hold_in   = '0;
        bus.req_valid = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            bus.req_port[i] = 3'((i + 1) % 5);
            bus.data_in[i]  = 32'h50000000 + i;
        end
        @(negedge clk);
        #1;
        checkV("all_pop", bus.pop, 5'b11111);
        @(posedge clk);
        #1;
        checkV("all_valid", bus.valid_out, 5'b11111);
        checkD("all_data0", bus.data_out[0], 32'h50000004);
        checkD("all_data1", bus.data_out[1], 32'h50000000);
        checkD("all_data2", bus.data_out[2], 32'h50000001);
        checkD("all_data3", bus.data_out[3], 32'h50000002);
        checkD("all_data4", bus.data_out[4], 32'h50000003);

        // Input 3 to its own port
        bus.req_valid   = 5'b01000;
        bus.req_port[3] = 3'd3;
        bus.data_in[3]  = 32'h33333333;
        @(negedge clk);
        #1;
        checkV("self_pop", bus.pop, 5'b01000);
        @(posedge clk);
        #1;
        checkV("self_valid", bus.valid_out, 5'b01000);
        checkD("self_data", bus.data_out[3], 32'h33333333);

        // Illegal destination
        bus.req_port[3] = 3'd6;
        @(negedge clk);
        #1;
        checkV("bad_pop", bus.pop, 5'b00000);
        checkB("bad_err_before_edge", bus.err_bad_port, 1'b0);
        @(posedge clk);
        #1;
        checkV("bad_valid", bus.valid_out, 5'b00000);
        checkB("bad_err_set", bus.err_bad_port, 1'b1);
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        checkB("bad_err_sticky", bus.err_bad_port, 1'b1);

        // Reset during a grant cycle restores the pointer
        bus.req_valid   = 5'b00110;
        bus.req_port[1] = 3'd1;
        bus.req_port[2] = 3'd1;
        bus.data_in[1]  = 32'h11110001;
        bus.data_in[2]  = 32'h22220002;
        @(negedge clk);
        #1;
        checkV("pre_rst_pop1", bus.pop, 5'b00010);
        @(posedge clk);
        #1;
        checkV("pre_rst_valid", bus.valid_out, 5'b00010);
        checkD("pre_rst_data", bus.data_out[1], 32'h11110001);
        @(negedge clk);
        #1;
        checkV("pre_rst_pop2", bus.pop, 5'b00100);
        #1;
        reset = 1'b0;
        #1;
        checkV("midrst_pop", bus.pop, 5'b00000);
        checkV("midrst_valid", bus.valid_out, 5'b00000);
        checkB("midrst_data_zero", bus.data_out == '0, 1'b1);
        checkB("midrst_err", bus.err_bad_port, 1'b0);
        @(posedge clk);
        #1;
        checkV("inrst_valid", bus.valid_out, 5'b00000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkV("postrst_pop", bus.pop, 5'b00010);
        @(posedge clk);
        #1;
        checkV("postrst_valid", bus.valid_out, 5'b00010);
        checkD("postrst_data", bus.data_out[1], 32'h11110001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_switch_allocator.md
ROUTER_SWITCH_ALLOCATOR -- requirements
Module: router_switch_allocator

Interface
REQ-001 Parameter NPORTS, default 5, number of router ports (0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST).
REQ-002 Parameter DATA_W, default 32, packet width (single-flit packets).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous active-low reset.
REQ-005 Port req_valid  input  NPORTS  input FIFO i holds a head packet.
REQ-006 Port req_port  input  NPORTS x 3  requested output port of input i head packet.
REQ-007 Port data_in  input  NPORTS x DATA_W  head packet of input FIFO i.
REQ-008 Port hold_in  input  NPORTS  downstream of output j cannot accept this cycle.
REQ-009 Port pop  output  NPORTS  input i head consumed at next rising edge (FIFO read enable).
REQ-010 Port valid_out  output  NPORTS  registered write request for output j.
REQ-011 Port data_out  output  NPORTS x DATA_W  registered packet for output j.
REQ-012 Port err_bad_port  output  1  sticky flag: valid request with req_port > NPORTS-1 seen.

Function
REQ-013 Each output j SHALL own a round-robin arbiter over inputs whose req_valid=1 and req_port=j.
REQ-014 Output j SHALL grant nothing in a cycle with hold_in[j]=1.
REQ-015 Search order for output j SHALL be ptr[j], ptr[j]+1, ... modulo NPORTS, wrapping 4->0.
REQ-016 On grant to input i, ptr[j] SHALL become (i+1) mod NPORTS at the next edge; otherwise ptr[j] unchanged.
REQ-017 pop[i] SHALL be combinational, asserted in the cycle input i is granted; at most one grant per input per cycle.
REQ-018 At the edge ending a grant cycle, data_out[j] SHALL load data_in[i] and valid_out[j] SHALL be 1 (latency 1 cycle).
REQ-019 valid_out[j] SHALL be 0 in every cycle following a cycle without a grant to output j; data_out[j] SHALL hold its last value.
REQ-020 A request with req_port >= NPORTS SHALL never be granted or popped and SHALL set err_bad_port until reset.
REQ-021 Request to its own port (req_port=i from input i) SHALL be arbitrated like any other.
REQ-022 Simultaneous requests to different outputs SHALL all be granted in the same cycle (up to NPORTS transfers/cycle).
REQ-023 An input whose req_valid drops without grant SHALL be dropped from arbitration without side effects.
REQ-024 hold_in SHALL not affect already-registered valid_out; hold applies only to new grants.

Reset
REQ-025 Asserted reset SHALL immediately force valid_out=0, data_out=0, all ptr=0, err_bad_port=0, pop=0.
REQ-026 Reset asserted mid-transfer SHALL discard the pending grant; the input FIFO SHALL not be popped.
REQ-027 First grant after reset release SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-028 router_pkg SHALL hold NPORTS, DATA_W, PORT_W=3 and the port enum (LOCAL, NORTH, EAST, SOUTH, WEST).
REQ-029 One sub-module rr_arbiter (NPORTS requests, pointer register, one-hot grant) SHALL be instantiated per output.
REQ-030 Data mux and output registers SHALL remain in router_switch_allocator.

Verification
REQ-031 Input 2 valid, req_port=1, data 0x845FFFFF, hold_in=0 -> pop[2]=1 same cycle; next cycle valid_out[1]=1, data_out[1]=0x845FFFFF.
REQ-032 Inputs 0,2,4 all request output 3 continuously from reset -> grants in order 0,2,4,0,... one per cycle, no starvation.
REQ-033 hold_in=5'b11111 for 10 cycles with input 2 requesting -> pop=0, valid_out=0 throughout; first grant the cycle hold_in[1] drops.
REQ-034 Inputs 0..4 request outputs 1,2,3,4,0 simultaneously -> all five pop in one cycle; next cycle valid_out=5'b11111 with matching data.
REQ-035 Input 3 requests req_port=6 -> no pop, no valid_out, err_bad_port=1 until reset.
REQ-036 reset asserted in grant cycle -> pop=0 immediately, valid_out=0, ptr back to 0 (next grant from input 0 first).
